// File: rtl/seq_mult_bcd.sv
// Sequential shift-add multiplier (unsigned or two's complement) followed by a
// sequential double-dabble conversion of the product magnitude to BCD.
module seq_mult_bcd #(
   parameter  int N      = 8,
   localparam int DIGITS = (2 * N) / 3 + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N-1:0]          a_in,
   input  logic [N-1:0]          b_in,
   input  logic                  signed_mode,
   input  logic                  start,
   output logic                  busy,
   output logic                  finish,
   output logic [2*N-1:0]        out,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd
);

   // Handshake: start is sampled only while idle; busy covers MULT, BCD and DONE;
   // finish pulses for one cycle in the cycle in which out/bcd/neg first show the new result.

   localparam int CW = $clog2(2 * N) + 1;
   localparam logic [CW-1:0] LAST_MULT = CW'(N - 1);
   localparam logic [CW-1:0] LAST_BCD  = CW'(2 * N - 1);

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      BCD,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [N-1:0]          mcand;
   logic [2*N:0]          acc;
   logic                  sign;
   logic [CW-1:0]         cnt;
   logic [2*N-1:0]        dbl_bin;
   logic [4*DIGITS-1:0]   dbl_bcd;

   logic [N-1:0]          a_mag;
   logic [N-1:0]          b_mag;
   logic [N:0]            upper_sum;
   logic [2*N:0]          acc_next;
   logic [4*DIGITS-1:0]   dbl_bcd_adj;
   logic [4*DIGITS+2*N-1:0] dbl_cat;
   logic [2*N-1:0]        prod;
   logic                  prod_neg;

   // |-2^(N-1)| still fits in N unsigned bits, so negation needs no extra width.
   assign a_mag = (signed_mode && a_in[N-1]) ? -a_in : a_in;
   assign b_mag = (signed_mode && b_in[N-1]) ? -b_in : b_in;

   assign upper_sum = acc[2*N:N] + {1'b0, (acc[0] ? mcand : {N{1'b0}})};
   assign acc_next  = {1'b0, upper_sum, acc[N-1:1]};

   always_comb begin
      dbl_bcd_adj = dbl_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (dbl_bcd[4*i +: 4] >= 4'd5)
            dbl_bcd_adj[4*i +: 4] = dbl_bcd[4*i +: 4] + 4'd3;
      end
   end

   assign dbl_cat  = {dbl_bcd_adj, dbl_bin} << 1;
   assign prod     = acc[2*N-1:0];
   assign prod_neg = sign && (prod != '0);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = MULT;
         MULT:    if (cnt == LAST_MULT) state_next = BCD;
         BCD:     if (cnt == LAST_BCD) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand   <= '0;
         acc     <= '0;
         sign    <= 1'b0;
         cnt     <= '0;
         dbl_bin <= '0;
         dbl_bcd <= '0;
         out     <= '0;
         bcd     <= '0;
         neg     <= 1'b0;
         finish  <= 1'b0;
      end else begin
         finish <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a_mag;
                  acc   <= {{(N+1){1'b0}}, b_mag};
                  sign  <= signed_mode & (a_in[N-1] ^ b_in[N-1]);
                  cnt   <= '0;
               end
            end
            MULT: begin
               acc <= acc_next;
               if (cnt == LAST_MULT) begin
                  // The final partial product seeds the converter directly.
                  cnt     <= '0;
                  dbl_bin <= acc_next[2*N-1:0];
                  dbl_bcd <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            BCD: begin
               dbl_bcd <= dbl_cat[4*DIGITS+2*N-1:2*N];
               dbl_bin <= dbl_cat[2*N-1:0];
               cnt     <= cnt + CW'(1);
            end
            DONE: begin
               out    <= prod_neg ? -prod : prod;
               bcd    <= dbl_bcd;
               neg    <= prod_neg;
               finish <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
